serial_add_sub_unit: RTL and testbench
======================================

// Module: serial_add_sub_unit
// PURPOSE
//   Bit-serial add/subtract engine. Consumes two WIDTH-bit operands; SUB selects
//   A - B, computed as A + ~B + 1 (two's-complement negate of B folded into the
//   carry-in). One single-bit full-adder slice is reused LSB-first, one bit per
//   clock. Sits downstream of the combinational negate/adder stages as the area-lean
//   arithmetic unit for the lab datapath.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>= 2)
// PORTS
//   clk           in   1      rising-edge clock; the only clock
//   rst_n         in   1      reset, synchronous, active-low
//   in_valid      in   1      operands + op present
//   in_ready      out  1      unit can accept operands (high only in IDLE)
//   A             in   WIDTH  operand A (two's complement)
//   B             in   WIDTH  operand B (two's complement)
//   SUB           in   1      0: A+B   1: A-B
//   out_valid     out  1      Y/flags valid (high only in DONE)
//   out_ready     in   1      consumer accepts result
//   Y             out  WIDTH  result, modulo 2^WIDTH
//   Cout          out  1      carry out of MSB (for SUB: 1 = no borrow)
//   Ovf           out  1      signed overflow
//   Zero          out  1      Y == 0
// BEHAVIOUR
//   Reset: clk edge with rst_n=0 -> state IDLE; bit counter, shift regs, carry,
//     Y, Cout, Ovf, Zero, out_valid all 0; in_ready = 1 on first cycle after reset.
//   Reset mid-operation: aborts immediately; partial result discarded, no out_valid.
//   FSM: IDLE -> SHIFT on in_valid & in_ready (accept edge): latch A, SUB ? ~B : B,
//     carry <= SUB, counter <= 0.
//   SHIFT: each cycle sum = a[0]^b[0]^c, c <= majority(a[0],b[0],c); sum shifted
//     into result MSB, a/b shifted right; counter++. On bit WIDTH-1, record
//     carry-in to MSB (cmsb) before updating c; after WIDTH cycles -> DONE.
//   DONE: out_valid=1; Y, Cout=c, Ovf=c^cmsb, Zero=(Y==0) held stable while
//     out_valid & !out_ready. On out_valid & out_ready -> IDLE, out_valid drops
//     next cycle.
//   Latency: accept edge to out_valid high = WIDTH+1 clocks (9 for WIDTH=8).
//   in_ready is 0 in SHIFT and DONE; in_valid there is ignored, operands not
//     latched. No accept in the same cycle a result is handed off (DONE->IDLE
//     first; next accept earliest one cycle later).
//   A, B, SUB sampled only on the accept edge; later changes have no effect.
//   Y/flags retain last result in IDLE until next DONE overwrites them.
//   Width rules: all arithmetic modulo 2^WIDTH; no sign extension; Ovf per
//     signed interpretation, Cout per unsigned.
//   Counter sized $clog2(WIDTH)+1; no wrap beyond WIDTH-1.
// TESTING
//   Reset then A=8'h05,B=8'h03,SUB=0 -> after 9 clks Y=8'h08,Cout=0,Ovf=0,Zero=0.
//   A=8'h05,B=8'h05,SUB=1 -> Y=8'h00, Cout=1, Ovf=0, Zero=1.
//   A=8'h7F,B=8'h01,SUB=0 -> Y=8'h80, Ovf=1, Cout=0; A=8'h80,B=8'h01,SUB=1 ->
//     Y=8'h7F, Ovf=1, Cout=1.
//   A=8'h00,B=8'h01,SUB=1 -> Y=8'hFF, Cout=0 (borrow), Ovf=0; hold out_ready=0
//     5 clks -> Y/out_valid stable; then out_ready=1 -> IDLE, in_ready=1 next clk.
//   Pulse in_valid with new operands during SHIFT -> ignored, first result unchanged.
//   Drop rst_n for one clk at bit 4 of an op -> out_valid never asserts, all
//     outputs 0, in_ready=1; fresh op 8'h10+8'h20 -> Y=8'h30.

Source files
------------

// File: rtl/serial_add_sub_unit.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice reused LSB-first,
// one bit per clock, with valid/ready handshakes on both the operand and result sides.
module serial_add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ALL_BITS = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             c_reg, c_next;
  logic             cmsb_reg, cmsb_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             zero_reg, zero_next;

  // Subtraction folds the negate of B into the operand: invert here, +1 via carry-in.
  logic [WIDTH-1:0] b_op;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign b_op[gi] = B[gi] ^ SUB;
    end
  endgenerate

  logic sum_bit;
  logic carry_bit;
  assign sum_bit   = a_reg[0] ^ b_reg[0] ^ c_reg;
  assign carry_bit = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign Y         = y_reg;
  assign Cout      = cout_reg;
  assign Ovf       = ovf_reg;
  assign Zero      = zero_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      y_reg     <= '0;
      cnt_reg   <= '0;
      c_reg     <= 1'b0;
      cmsb_reg  <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      res_reg   <= res_next;
      y_reg     <= y_next;
      cnt_reg   <= cnt_next;
      c_reg     <= c_next;
      cmsb_reg  <= cmsb_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      zero_reg  <= zero_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    res_next   = res_reg;
    y_next     = y_reg;
    cnt_next   = cnt_reg;
    c_next     = c_reg;
    cmsb_next  = cmsb_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    zero_next  = zero_reg;

    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          a_next     = A;
          b_next     = b_op;
          c_next     = SUB;
          cnt_next   = '0;
          res_next   = '0;
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_reg == ALL_BITS) begin
          // Every bit is in: publish result and flags together.
          y_next     = res_reg;
          cout_next  = c_reg;
          ovf_next   = c_reg ^ cmsb_reg;
          zero_next  = (res_reg == '0);
          state_next = S_DONE;
        end else begin
          res_next = {sum_bit, res_reg[WIDTH-1:1]};
          a_next   = {1'b0, a_reg[WIDTH-1:1]};
          b_next   = {1'b0, b_reg[WIDTH-1:1]};
          c_next   = carry_bit;
          if (cnt_reg == LAST_BIT) begin
            cmsb_next = c_reg;
          end
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed bench for serial_add_sub_unit: arithmetic reference model, per-cycle result
// comparison, and hand-computed literal expectations for each directed operation.
module tb_serial_add_sub_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         SUB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
  logic         Cout;
  logic         Ovf;
  logic         Zero;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  logic [10:0] exp_q[$];

  serial_add_sub_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .SUB(SUB), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .Cout(Cout), .Ovf(Ovf), .Zero(Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Returns {zero, ovf, cout, y} from plain unsigned/signed arithmetic.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ua, ub, sa, sb, sr;
    logic [7:0] y;
    logic c, o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      y  = a - b;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      y  = a + b;
      c  = (ua + ub) > 255;
      sr = sa + sb;
    end
    o = (sr > 127) || (sr < -128);
    return {(y == 8'h00), o, c, y};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(A, B, SUB));
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("model_y",    32'(Y),    32'(exp_q[0][7:0]));
        chk("model_cout", 32'(Cout), 32'(exp_q[0][8]));
        chk("model_ovf",  32'(Ovf),  32'(exp_q[0][9]));
        chk("model_zero", 32'(Zero), 32'(exp_q[0][10]));
        if (out_ready) void'(exp_q.pop_front());
      end
      chk("ready_valid_exclusive", 32'(in_ready), 32'd0);
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] ey, input logic ec, input logic eo, input logic ez,
                        input bit poke);
    int c0;
    bit found;
    $display("op A=%02h B=%02h SUB=%0d expect Y=%02h C=%0d O=%0d Z=%0d", a, b, s, ey, ec, eo, ez);
    chk("model_pin", 32'(model(a, b, s)), 32'({ez, eo, ec, ey}));
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("in_ready_wait", 32'(found), 32'd1);
    A = a; B = b; SUB = s; in_valid = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    chk("busy_after_accept", 32'(in_ready), 32'd0);
    in_valid = poke;
    A = 8'($urandom); B = 8'($urandom); SUB = 1'($urandom);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("out_valid_timeout", 32'(found), 32'd1);
    chk("latency", 32'(cyc - c0), 32'(W + 1));
    chk("y",    32'(Y),    32'(ey));
    chk("cout", 32'(Cout), 32'(ec));
    chk("ovf",  32'(Ovf),  32'(eo));
    chk("zero", 32'(Zero), 32'(ez));
  endtask

  task automatic handoff();
    @(posedge clk); #1;
    chk("idle_after_handoff_valid", 32'(out_valid), 32'd0);
    chk("idle_after_handoff_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; SUB = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y",         32'(Y),         32'd0);
    chk("rst_flags",     32'({Cout, Ovf, Zero}), 32'd0);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 0); handoff();
    run_op(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0); handoff();
    chk("retain_y_idle", 32'(Y), 32'h00);
    chk("retain_zero_idle", 32'(Zero), 32'd1);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0); handoff();
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 0); handoff();
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0); handoff();
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0); handoff();
    run_op(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 0); handoff();

    // Result held while consumer stalls.
    out_ready = 1'b0;
    run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_y",     32'(Y),         32'hFF);
    end
    out_ready = 1'b1;
    handoff();

    // Operands offered during SHIFT/DONE and across the handoff edge are ignored.
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1);
    @(posedge clk); #1;
    chk("no_accept_on_handoff", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Abort mid-operation with reset at bit 4.
    A = 8'h55; B = 8'h0F; SUB = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_y",         32'(Y),         32'd0);
    chk("abort_flags",     32'({Cout, Ovf, Zero}), 32'd0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("abort_no_valid", 32'(cnt), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 0); handoff();

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
